// File: rtl/rf_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package rf_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REGS_DEF = 32;
  localparam int unsigned NRD_DEF  = 2;

  typedef logic [$clog2(REGS_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]         xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue handshake, writeback clear, busy count.
module rf_scoreboard #(
  parameter int unsigned REGS = 32,
  parameter int unsigned AW   = $clog2(REGS),
  parameter int unsigned CW   = $clog2(REGS + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            write_enable_i,
  input  logic [AW-1:0]   write_addr_i,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_addr_i,
  output logic            issue_ready_o,
  output logic [REGS-1:0] busy_o,
  output logic [CW-1:0]   busy_cnt_o
);

  logic [REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Ready only when the destination has no pending write; x0 is always free.
  assign issue_ready_o = !busy_q[issue_addr_i] || (issue_addr_i == '0);

  // Next busy vector: writeback clears, accepted issue sets (issue wins on collision).
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    if (write_enable_i && (write_addr_i != '0)) begin
      busy_d[write_addr_i] = 1'b0;
    end
    if (issue_valid_i && issue_ready_o && (issue_addr_i != '0)) begin
      busy_d[issue_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    for (int i = 0; i < int'(REGS); i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  // Busy bits and their population count update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/rf_riscv_sb.sv
// Scoreboarded RISC-V register file: NRD combinational read ports, one write
// port, async clear, busy tracking for RAW/WAW hazard detection.
// Optional macro RF_BYPASS_EN: same-cycle write-to-read forwarding.
module rf_riscv_sb
  import rf_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned REGS = REGS_DEF,
  parameter int unsigned NRD  = NRD_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       write_enable_i,
  input  logic [$clog2(REGS)-1:0]    write_addr_i,
  input  logic [XLEN-1:0]            write_data_i,
  input  logic [NRD*$clog2(REGS)-1:0] read_addr_i,
  output logic [NRD*XLEN-1:0]        read_data_o,
  output logic [NRD-1:0]             read_busy_o,
  input  logic                       issue_valid_i,
  input  logic [$clog2(REGS)-1:0]    issue_addr_i,
  output logic                       issue_ready_o,
  output logic [$clog2(REGS+1)-1:0]  busy_cnt_o
);

  localparam int unsigned AW = $clog2(REGS);
  localparam int unsigned CW = $clog2(REGS + 1);

  logic [XLEN-1:0] mem_q [REGS];
  logic [XLEN-1:0] mem_d [REGS];
  logic [REGS-1:0] busy;

  rf_scoreboard #(
    .REGS (REGS),
    .AW   (AW),
    .CW   (CW)
  ) u_sb (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .write_enable_i (write_enable_i),
    .write_addr_i   (write_addr_i),
    .issue_valid_i  (issue_valid_i),
    .issue_addr_i   (issue_addr_i),
    .issue_ready_o  (issue_ready_o),
    .busy_o         (busy),
    .busy_cnt_o     (busy_cnt_o)
  );

  // Next storage contents; writes to x0 are dropped so it stays zero.
  always_comb begin
    mem_d = mem_q;
    if (write_enable_i && (write_addr_i != '0)) begin
      mem_d[write_addr_i] = write_data_i;
    end
  end

  // Storage array, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(REGS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read muxes, optionally forwarding the in-flight writeback.
  always_comb begin
    logic [AW-1:0] ra;
    read_data_o = '0;
    read_busy_o = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      ra = read_addr_i[k*AW +: AW];
      read_data_o[k*XLEN +: XLEN] = mem_q[ra];
      read_busy_o[k]              = busy[ra];
`ifdef RF_BYPASS_EN
      if (write_enable_i && (write_addr_i == ra) && (ra != '0)) begin
        read_data_o[k*XLEN +: XLEN] = write_data_i;
        read_busy_o[k] = issue_valid_i && issue_ready_o && (issue_addr_i == ra);
      end
`endif
    end
  end

endmodule

// File: doc/rf_riscv_sb.md
Name: rf_riscv_sb

Overview:
- Parametrised successor to the core register file: XLEN-wide, REGS-deep, NRD combinational read ports, one synchronous write port.
- Adds asynchronous clearing of all registers and a per-register busy scoreboard, so the decode stage can detect RAW and WAW hazards against in-flight writebacks.
- Sits between decode/issue (read and issue side) and writeback (write side) of the RISC-V core.

Parameters:
- XLEN, 32, data width in bits.
- REGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports, 1..4.
- AW, $clog2(REGS), localparam, address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- write_enable_i  in  1  writeback strobe.
- write_addr_i  in  AW  writeback destination register.
- write_data_i  in  XLEN  writeback data.
- read_addr_i  in  NRD x AW  read addresses, packed array, port 0 in the LSBs.
- read_data_o  out  NRD x XLEN  read data.
- read_busy_o  out  NRD  the addressed register has a pending write.
- issue_valid_i  in  1  decode requests to mark a destination register busy.
- issue_addr_i  in  AW  destination register of the issuing instruction.
- issue_ready_o  out  1  the issue is accepted this cycle.
- busy_cnt_o  out  $clog2(REGS+1)  number of busy registers.

Behaviour:
- Reset (rst_i=1, asynchronous): all registers = 0, all busy bits = 0, busy_cnt_o = 0. Outputs follow combinationally: read_data_o = 0, read_busy_o = 0, issue_ready_o = 1.
- Register 0: always reads 0 and is never busy. Writes to it are discarded; issues to it are accepted (issue_ready_o = 1) with no state change.
- Reads: combinational, zero latency. read_data_o[k] = mem[read_addr_i[k]]; read_busy_o[k] = busy[read_addr_i[k]].
- Write: when write_enable_i=1 and write_addr_i != 0, mem[write_addr_i] <= write_data_i and busy[write_addr_i] <= 0 at the next edge.
  - A write to a register that is not busy is legal; busy stays 0.
- Issue handshake: issue_ready_o = !busy[issue_addr_i] || issue_addr_i == 0.
  - A WAW stall holds ready low.
  - On issue_valid_i && issue_ready_o with a non-zero address: busy[issue_addr_i] <= 1 at the next edge.
  - If valid is asserted while ready=0, nothing happens; decode must hold the request.
  - Ready does not look ahead to a same-cycle write: an issue to a busy register is refused even if the writeback for that register arrives in the same cycle.
- Simultaneous write and issue to the same non-zero register (only possible when it is not busy): the data is written and busy ends at 1, i.e. the issue wins.
- Simultaneous write and issue to different registers: both take effect.
- busy_cnt_o: registered population count of busy bits, updated in the same edge as the busy bits. Never exceeds REGS-1.
- Read-during-write, default build: a read returns the old value, and read_busy_o reflects pre-edge state.
- A reset in the middle of operation discards all pending busy state immediately; any writeback after reset is an ordinary write.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding on every read port. When write_enable_i=1, write_addr_i == read_addr_i[k] and the address is non-zero:
  - read_data_o[k] = write_data_i in the same cycle;
  - read_busy_o[k] = 0, unless the same register is being issued in the same cycle, in which case it is 1.
  - The forwarding path is purely combinational; stored state is identical with and without the macro.
- Not defined: no forwarding; the old value is returned until the next cycle.

Decomposition:
- Package rf_pkg holds XLEN_DEF, REGS_DEF, NRD_DEF, and the typedefs reg_addr_t and xlen_t.
- Sub-module rf_scoreboard holds the busy vector, the issue handshake and busy_cnt_o. It is instantiated once. The storage array and read muxing stay in the top module.

Test Plan:
- Reset then read: assert rst_i mid-cycle, read addresses 0..31 -> all data 0, busy 0, busy_cnt_o=0, issue_ready_o=1.
- Write then read: write x5=0xDEADBEEF; next cycle read port0=x5 and port1=x0 -> 0xDEADBEEF and 0. Write x0=0x1234 -> x0 still reads 0.
- Scoreboard: issue x7 -> next cycle read_busy=1, busy_cnt_o=1. Issue x7 again -> issue_ready_o=0 and count stays 1. Write x7=0x55 -> busy 0, count 0, read 0x55.
- Same-register collision: issue x9 and write x9=0xA5 in the same cycle -> x9 reads 0xA5, busy=1, count=1.
- Bypass: write x3=0x77 with read port0=x3 in the same cycle -> 0x77 when RF_BYPASS_EN is defined, old value when it is not.
- Reset while 3 registers are busy -> busy_cnt_o=0 immediately and all issues ready.
